// File: rtl/ksa8_sub_pipe.sv
// rtl/ksa8_sub_pipe.sv - 3-stage pipelined 8-bit Kogge-Stone subtractor (a - b - bin)
// Each prefix level has one register stage. Valid/ready backpressure is carried through every stage.
module ksa8_sub_pipe #(
    parameter bit BORROW_IN_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf
);

    // S1: bit propagate, carry-in, span-2 group terms
    logic       v1_q, v1_d;
    logic [7:0] p1_q, p1_d;
    logic       cin1_q, cin1_d;
    logic [7:0] gg1_q, gg1_d;
    logic [5:0] pp1_q, pp1_d;

    // S2: span-4 group terms
    logic       v2_q, v2_d;
    logic [7:0] p2_q, p2_d;
    logic       cin2_q, cin2_d;
    logic [7:0] gg2_q, gg2_d;
    logic [3:0] pp2_q, pp2_d;

    // S3: final sum and flags
    logic       v3_q, v3_d;
    logic [7:0] diff_q, diff_d;
    logic       bout_q, bout_d;
    logic       ovf_q, ovf_d;

    logic       adv1, adv2, adv3;
    logic       cin;
    logic [7:0] bi, p, g, g_f, p_f, pp1_full, c;

    always_comb begin
        adv3     = ~v3_q | out_ready;
        adv2     = ~v2_q | adv3;
        adv1     = ~v1_q | adv2;
        in_ready = rst_n & adv1;

        // Level 1: carry-in folded into bit 0, so group P at bit 0 is 0
        bi    = ~b;
        cin   = ~(bin & BORROW_IN_EN);
        p     = a ^ bi;
        g     = a & bi;
        g_f   = {g[7:1], g[0] | (p[0] & cin)};
        p_f   = {p[7:1], 1'b0};
        gg1_d = g_f | (p_f & {g_f[6:0], 1'b0});
        pp1_d = p_f[7:2] & p_f[6:1];
        p1_d  = p;
        cin1_d = cin;
        v1_d  = adv1 ? in_valid : v1_q;
        if (!(adv1 && in_valid)) begin
            p1_d   = p1_q;
            cin1_d = cin1_q;
            gg1_d  = gg1_q;
            pp1_d  = pp1_q;
        end

        // Level 2
        pp1_full = {pp1_q, 2'b00};
        gg2_d    = gg1_q | (pp1_full & {gg1_q[5:0], 2'b00});
        pp2_d    = pp1_q[5:2] & pp1_q[3:0];
        p2_d     = p1_q;
        cin2_d   = cin1_q;
        v2_d     = adv2 ? v1_q : v2_q;
        if (!(adv2 && v1_q)) begin
            gg2_d  = gg2_q;
            pp2_d  = pp2_q;
            p2_d   = p2_q;
            cin2_d = cin2_q;
        end

        // Level 3 gives every carry; borrow is the inverted carry-out
        c      = gg2_q | ({pp2_q, 4'b0000} & {gg2_q[3:0], 4'b0000});
        diff_d = p2_q ^ {c[6:0], cin2_q};
        bout_d = ~c[7];
        ovf_d  = c[6] ^ c[7];
        v3_d   = adv3 ? v2_q : v3_q;
        if (!(adv3 && v2_q)) begin
            diff_d = diff_q;
            bout_d = bout_q;
            ovf_d  = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            p1_q   <= '0;
            cin1_q <= 1'b0;
            gg1_q  <= '0;
            pp1_q  <= '0;
            v2_q   <= 1'b0;
            p2_q   <= '0;
            cin2_q <= 1'b0;
            gg2_q  <= '0;
            pp2_q  <= '0;
            v3_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            p1_q   <= p1_d;
            cin1_q <= cin1_d;
            gg1_q  <= gg1_d;
            pp1_q  <= pp1_d;
            v2_q   <= v2_d;
            p2_q   <= p2_d;
            cin2_q <= cin2_d;
            gg2_q  <= gg2_d;
            pp2_q  <= pp2_d;
            v3_q   <= v3_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule
